// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, frame error and overrun reporting
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);
  localparam int CPB  = clk_freq / baud_rate;
  localparam int HALF = CPB / 2;
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
  if (CPB < 4 || CPB > 65535) begin : g_bad_cpb
    $error("uart_rx: clk_freq/baud_rate must be within 4..65535");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic [1:0]  sync;
  logic        rx_sync;
  assign rx_sync = sync[1];
  assign busy    = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      sync        <= 2'b11;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync        <= {sync[0], rx};
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (rx_read && rx_valid) rx_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_sync) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF_M1) begin
          cnt   <= '0;
          idx   <= '0;
          state <= rx_sync ? IDLE : DATA;
        end else cnt <= cnt + 16'd1;
        DATA: if (cnt == CPB_M1) begin
          cnt   <= '0;
          shift <= {rx_sync, shift[7:1]};
          idx   <= idx + 3'd1;
          if (idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 16'd1;
        STOP: if (cnt == CPB_M1) begin
          cnt <= '0;
          if (rx_sync) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid && !rx_read;
            state    <= IDLE;
          end else begin
            frame_error <= 1'b1;
            state       <= WAIT_HIGH;
          end
        end else cnt <= cnt + 16'd1;
        WAIT_HIGH: if (rx_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate in bit/s.
REQ-003 Derived constants: CPB = clk_freq/baud_rate (integer division; default 104), HALF = CPB/2 (default 52); elaboration SHALL fail if CPB < 4 or CPB > 65535.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-007 rx_read  input  1  one-cycle pulse from consumer acknowledging rx_data.
REQ-008 rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-009 rx_valid  output  1  level; high while an unread byte is held.
REQ-010 frame_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 overrun  output  1  one-cycle pulse when a byte completes while rx_valid is high and rx_read is low.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH, and one 16-bit cycle counter.
REQ-015 IDLE: at cycle T0, where rx_sync==0 -> START, counter=0.
REQ-016 START: the counter increments each cycle; at counter==HALF-1 (cycle T0+HALF), rx_sync==0 -> DATA (counter=0, bit index=0); rx_sync==1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: at counter==CPB-1, the FSM SHALL shift rx_sync into the MSB of an 8-bit shift register (shift right), reset the counter and increment the bit index; after the 8th sample -> STOP.
REQ-018 Data bit n (n=0..7) SHALL be sampled at T0+HALF+(n+1)*CPB; the stop bit SHALL be sampled at T0+HALF+9*CPB.
REQ-019 STOP sample==1: rx_data<=shift register and rx_valid<=1, both effective at T0+HALF+9*CPB+1; then -> IDLE.
REQ-020 STOP sample==0: frame_error=1 for one cycle at T0+HALF+9*CPB+1; rx_data and rx_valid unchanged; then -> WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rx_sync==1, then -> IDLE; a held-low line (break) SHALL NOT start a new frame.
REQ-022 rx_read with rx_valid==1 SHALL clear rx_valid on the next cycle; rx_read with rx_valid==0 SHALL be ignored.
REQ-023 Good frame completion with rx_valid==1 and rx_read==0 SHALL overwrite rx_data, keep rx_valid=1 and pulse overrun.
REQ-024 Good frame completion in the same cycle as rx_read SHALL load rx_data, keep rx_valid=1 and produce no overrun pulse.
REQ-025 Reception SHALL continue regardless of rx_valid; no back-pressure on the line.
REQ-026 Counter arithmetic SHALL be unsigned 16-bit; the counter SHALL never exceed CPB-1.

Reset
REQ-027 On reset: state=IDLE, counter=0, bit index=0, shift register=0x00, synchronizer flops=1, rx_data=0x00, rx_valid=0, frame_error=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without an output pulse; after release, the FSM SHALL wait in IDLE for the next falling edge of rx_sync.

Verification
REQ-029 The bench SHALL drive byte 0x55 at 9600 baud with default parameters -> rx_data=0x55, rx_valid rises 989 cycles after rx_sync first goes low, frame_error=0.
REQ-030 The bench SHALL drive rx low for 20 cycles, then high -> FSM returns to IDLE at T0+52, and rx_valid, frame_error and overrun all stay 0.
REQ-031 The bench SHALL drive 0xA5 with the stop bit 0, then hold rx low 500 cycles -> one frame_error pulse, rx_valid=0, busy stays high until rx returns high, and no second frame starts.
REQ-032 The bench SHALL send 0x12 then 0x34 with no rx_read -> rx_data=0x34, rx_valid=1, one overrun pulse; repeat with rx_read in the completion cycle -> no overrun.
REQ-033 The bench SHALL assert reset at data bit 4 of 0xFF, release it, then send 0x0F -> no output during the aborted frame, then rx_data=0x0F, rx_valid=1.
REQ-034 The bench SHALL pulse rx_read while rx_valid=1 -> rx_valid=0 on the next cycle, and rx_data unchanged.
